pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised inter-stage pipeline register, the generalised successor to the fixed ID/EX latch.
- Carries a control bundle (WB/M/EX bits) and a data bundle between any two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so stalls never create a combinational ready path.
- Supports synchronous flush, which inserts a bubble with zeroed control (NOP), and a saturating stall-cycle counter for performance monitoring.

Parameters:
CTRL_W, 25, control bundle width (default: WB 5 + M 10 + EX 10)
DATA_W, 192, data bundle width (default: pc, rd1, rd2, zer, ser, instr; 6 x 32)
CNT_W, 16, stall counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries (branch/jump/exception)
in_valid  in  1  upstream stage presents an entry
in_ready  out  1  stage can accept; depends on registered state only
in_ctrl  in  CTRL_W  control bundle from upstream
in_data  in  DATA_W  data bundle from upstream
out_valid  out  1  entry available to downstream
out_ready  in  1  downstream accepts the entry
out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0
out_data  out  DATA_W  data bundle of the head entry
occupancy  out  2  number of held entries (0..2)
stall_cycles  out  CNT_W  saturating count of cycles with out_valid & !out_ready

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; both slots have ctrl=0 and data=0; out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cycles=0. in_ready=1 after reset.
- Storage: a main slot (head, drives outputs) and a skid slot. Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (occupancy 0), ONE (1), FULL (2).
- in_ready = (state != FULL). out_valid = (state != EMPTY).
- EMPTY: in_fire -> main<=in, goes to ONE. No in_fire -> stays EMPTY.
- ONE:
  - in_fire & out_fire -> main<=in, stays ONE.
  - in_fire & !out_fire -> skid<=in, goes to FULL.
  - !in_fire & out_fire -> goes to EMPTY, and main ctrl is cleared to 0.
  - Neither -> hold.
- FULL: in_ready=0.
  - out_fire -> main<=skid, skid ctrl cleared, goes to ONE.
  - No out_fire -> hold.
- Latency: 1 cycle from in_fire to out_valid when empty. Full throughput of 1 entry/cycle while out_ready=1.
- Flush has highest priority over all fire events:
  - Next state is EMPTY; both slot ctrl fields are zeroed; data fields are held.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle counts as consumed downstream (the head was visible that cycle).
  - The stall counter is not affected by flush.
- out_ctrl is gated: equals main ctrl when out_valid=1, otherwise 0. A bubble is therefore always a NOP.
- out_data is not gated: it shows main data even when invalid.
- stall_cycles increments by 1 on each cycle with out_valid & !out_ready and saturates at 2^CNT_W-1 without wrapping. Cleared only by reset.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Ordering: entries leave strictly in arrival order. No entry is duplicated or lost except by flush or reset.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum {EMPTY, ONE, FULL};
  - widths WB_W=5, M_W=10, EX_W=10, CTRL_W_DEF=25;
  - NOP_CTRL = '0.
- One sub-module, pipe_slot: enable-loaded register pair (ctrl, data) with a synchronous ctrl-clear input and async active-low reset. Instantiated twice, as main and skid.
- The state machine and stall counter live in the top module.

Test Plan:
1. Reset, then in_valid=1 with ctrl=0x1ABCDEF, data=pattern A, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x1ABCDEF, out_data=A, occupancy=1.
2. Stream 8 entries back-to-back with out_ready=1 -> 8 consecutive outputs in order, in_ready stays 1, stall_cycles=0.
3. Hold out_ready=0, push entries A,B,C -> A and B accepted, in_ready=0 on the cycle after B, C held upstream. Raise out_ready -> outputs A,B,C in order; stall_cycles equals the number of cycles out_ready was low with out_valid=1.
4. FULL state plus flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and the incoming entry does not appear.
5. CNT_W=4: hold out_ready=0 with a valid head for 20 cycles -> stall_cycles reaches 15 and stays at 15.
6. Assert rst_n=0 between clock edges while FULL -> out_valid, out_ctrl, occupancy and stall_cycles go to 0 immediately (asynchronously); in_ready=1 after release.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : shared types and constants for the skid pipeline stage    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam int WB_W       = 5;
  localparam int M_W        = 10;
  localparam int EX_W       = 10;
  localparam int CTRL_W_DEF = WB_W + M_W + EX_W;

  localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_slot : enable-loaded ctrl/data register pair with ctrl clear    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_slot #(
  parameter int CTRL_W = 25,
  parameter int DATA_W = 192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clr_ctrl,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear wins over load so a killed slot can never hold a live instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (i_clr_ctrl) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_skid : valid/ready pipeline register with 2-entry skid,   |
// | flush-to-NOP and saturating stall counter.  Rev 1.0                  |
// +----------------------------------------------------------------------+
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = 192,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_stall;

  logic              w_in_fire;
  logic              w_out_fire;

  logic              w_main_load;
  logic              w_main_clr;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;

  logic              w_skid_load;
  logic              w_skid_clr;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_in_fire) w_state_nxt = ONE;
        ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_nxt = FULL;
          else if (!w_in_fire && w_out_fire) w_state_nxt = EMPTY;
        end
        FULL:    if (w_out_fire) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs come only from r_state, so ready never sees out_ready.
  always_comb begin
    in_ready      = (r_state != FULL);
    out_valid     = (r_state != EMPTY);
    occupancy     = 2'd0;
    w_main_load   = 1'b0;
    w_main_clr    = flush;
    w_skid_load   = 1'b0;
    w_skid_clr    = flush;
    w_main_ctrl_d = in_ctrl;
    w_main_data_d = in_data;
    case (r_state)
      EMPTY: begin
        occupancy   = 2'd0;
        w_main_load = w_in_fire & ~flush;
      end
      ONE: begin
        occupancy   = 2'd1;
        w_main_load = w_in_fire & w_out_fire & ~flush;
        w_skid_load = w_in_fire & ~w_out_fire & ~flush;
        w_main_clr  = flush | (~w_in_fire & w_out_fire);
      end
      FULL: begin
        occupancy     = 2'd2;
        w_main_load   = w_out_fire & ~flush;
        w_skid_clr    = flush | w_out_fire;
        w_main_ctrl_d = w_skid_ctrl;
        w_main_data_d = w_skid_data;
      end
      default: occupancy = 2'd0;
    endcase
    out_ctrl = out_valid ? w_main_ctrl : '0;
  end

  assign out_data     = w_main_data;
  assign stall_cycles = r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_main_load),
    .i_clr_ctrl (w_main_clr),
    .i_ctrl     (w_main_ctrl_d),
    .i_data     (w_main_data_d),
    .o_ctrl     (w_main_ctrl),
    .o_data     (w_main_data)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_skid_load),
    .i_clr_ctrl (w_skid_clr),
    .i_ctrl     (in_ctrl),
    .i_data     (in_data),
    .o_ctrl     (w_skid_ctrl),
    .o_data     (w_skid_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_skid : scoreboard bench with an in-order queue model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int CTRL_W  = 25;
  localparam int DATA_W  = 192;
  localparam int CNT_W   = 4;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cycles;

  int total = 0;
  int bad   = 0;

  entry_t mq[$];
  int     m_stall = 0;

  pipe_stage_skid #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model: an ordered queue of at most two entries plus a saturating counter.
  always @(negedge clk) begin
    bit     exp_valid;
    bit     acc;
    entry_t head;
    if (!rst_n) begin
      mq.delete();
      m_stall = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ctrl", out_ctrl, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_stall", stall_cycles, 0);
    end else begin
      exp_valid = (mq.size() != 0);
      acc       = in_valid && (mq.size() < 2);
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, mq.size() < 2);
      check("occupancy", occupancy, mq.size());
      check("stall_cycles", stall_cycles, m_stall);
      if (exp_valid) begin
        head = mq[0];
        check("out_ctrl", out_ctrl, head.c);
        check("out_data", out_data, head.d);
      end else begin
        check("bubble_ctrl", out_ctrl, 0);
      end
      if (exp_valid && !out_ready && m_stall < SAT_MAX) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        if (exp_valid && out_ready) void'(mq.pop_front());
        if (acc) mq.push_back('{c: in_ctrl, d: in_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] pat_a;
    bit                taken;
    rst_n = 1'b0;
    idle(1'b1);
    #12 rst_n = 1'b1;
    tick();

    // 1: single entry, one-cycle latency
    pat_a = {6{32'hA5C3_0F1E}};
    drive(1'b1, 25'h1ABCDEF, pat_a, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    check("t1_valid", out_valid, 1);
    check("t1_ctrl", out_ctrl, 25'h1ABCDEF);
    check("t1_data", out_data, pat_a);
    check("t1_occ", occupancy, 1);
    tick();

    // 2: back-to-back stream
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, CTRL_W'($urandom), rand_data(), 1'b1, 1'b0);
      tick();
    end
    idle(1'b1);
    check("t2_stall", stall_cycles, 0);
    tick(); tick();

    // 3: stall with A,B,C then drain
    drive(1'b1, 25'h0000A0A, rand_data(), 1'b0, 1'b0); tick();
    drive(1'b1, 25'h0000B0B, rand_data(), 1'b0, 1'b0); tick();
    drive(1'b1, 25'h0000C0C, rand_data(), 1'b0, 1'b0);
    check("t3_full_ready", in_ready, 0);
    tick(); tick();
    out_ready = 1'b1;
    taken = 1'b0;
    for (int i = 0; i < 10 && !taken; i++) begin
      taken = in_ready;
      tick();
    end
    check("t3_c_taken", taken, 1);
    idle(1'b1);
    tick(); tick(); tick();

    // 4: flush while FULL with an incoming entry
    drive(1'b1, CTRL_W'($urandom), rand_data(), 1'b0, 1'b0); tick();
    drive(1'b1, CTRL_W'($urandom), rand_data(), 1'b0, 1'b0); tick();
    drive(1'b1, 25'h1FFFFFF, rand_data(), 1'b0, 1'b1); tick();
    idle(1'b1);
    check("t4_valid", out_valid, 0);
    check("t4_ctrl", out_ctrl, 0);
    check("t4_occ", occupancy, 0);
    tick(); tick();

    // 5: counter saturation
    drive(1'b1, 25'h0123456, rand_data(), 1'b0, 1'b0); tick();
    idle(1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("t5_sat", stall_cycles, SAT_MAX);
    out_ready = 1'b1;
    tick(); tick();

    // 6: asynchronous reset while FULL
    drive(1'b1, CTRL_W'($urandom), rand_data(), 1'b0, 1'b0); tick();
    drive(1'b1, CTRL_W'($urandom), rand_data(), 1'b0, 1'b0); tick();
    idle(1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_ctrl", out_ctrl, 0);
    check("t6_occ", occupancy, 0);
    check("t6_stall", stall_cycles, 0);
    tick();
    rst_n = 1'b1;
    #1 check("t6_ready", in_ready, 1);
    tick();

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, CTRL_W'($urandom), rand_data(),
            ($urandom % 3) != 0, ($urandom % 20) == 0);
      tick();
    end
    idle(1'b1);
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
